// File: rtl/serial_word_receiver_if.sv
// Serial link bundle between a bit-strobed stream source/consumer and the word receiver.
// The master side drives the serial stream and ack; the slave (receiver) drives the word outputs.
interface serial_word_receiver_if #(
    parameter int WIDTH = 4
);
    logic             frame;
    logic             sen;
    logic             sin;
    logic             dir;
    logic             ack;
    logic [WIDTH-1:0] Q;
    logic             valid;
    logic             ovr;
    logic             ferr;
    logic             perr;

    modport master (
        output frame, sen, sin, dir, ack,
        input  Q, valid, ovr, ferr, perr
    );

    modport slave (
        input  frame, sen, sin, dir, ack,
        output Q, valid, ovr, ferr, perr
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Framed, bit-strobed serial-in/parallel-out word receiver with valid/ack output handshake.
// Define SERIAL_RX_PARITY_EN to expect one trailing even-parity bit per frame and report perr.
module serial_word_receiver #(
    parameter int WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  clr,
    serial_word_receiver_if.slave bus
);
    localparam int               CNT_W    = $clog2(WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PAR, WAIT} state_e;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, WAIT} state_e;
`endif

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] word_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             dir_q;
    logic             dir_d;
    logic             valid_q;
    logic             ovr_q;
    logic             ferr_q;
    logic             deliver;
`ifdef SERIAL_RX_PARITY_EN
    logic             perr_q;
    logic             perr_d;
`endif

    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        dir_d   = (state_q == IDLE || cnt_q == '0) ? bus.dir : dir_q;
        shreg_d = dir_d ? {shreg_q[WIDTH-2:0], bus.sin} : {bus.sin, shreg_q[WIDTH-1:1]};
        cnt_d   = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        deliver = 1'b0;
        word_d  = shreg_d;
`ifdef SERIAL_RX_PARITY_EN
        perr_d  = (^shreg_q) ^ bus.sin;
        if (state_q == PAR && bus.frame && bus.sen) begin
            deliver = 1'b1;
            word_d  = shreg_q;
        end
`else
        if (state_q == SHIFT && bus.frame && bus.sen && cnt_d == CNT_FULL) begin
            deliver = 1'b1;
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            q_q     <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            ferr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.frame) begin
                        state_q <= SHIFT;
                        cnt_q   <= bus.sen ? CNT_W'(1) : '0;
                        if (bus.sen) begin
                            shreg_q <= shreg_d;
                            dir_q   <= dir_d;
                        end
                    end
                end
                SHIFT: begin
                    if (!bus.frame) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        ferr_q  <= 1'b1;
                    end else if (bus.sen) begin
                        shreg_q <= shreg_d;
                        dir_q   <= dir_d;
                        cnt_q   <= cnt_d;
                        if (cnt_d == CNT_FULL) begin
`ifdef SERIAL_RX_PARITY_EN
                            state_q <= PAR;
`else
                            state_q <= WAIT;
`endif
                        end
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PAR: begin
                    if (!bus.frame) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        ferr_q  <= 1'b1;
                    end else if (bus.sen) begin
                        state_q <= WAIT;
                    end
                end
`endif
                WAIT: begin
                    if (!bus.frame) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // A word completing while the previous one is still unconsumed is dropped.
            if (deliver) begin
                if (!valid_q || bus.ack) begin
                    q_q     <= word_d;
                    valid_q <= 1'b1;
`ifdef SERIAL_RX_PARITY_EN
                    perr_q  <= perr_d;
`endif
                end else begin
                    ovr_q <= 1'b1;
                end
            end else if (valid_q && bus.ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.Q     = q_q;
    assign bus.valid = valid_q;
    assign bus.ovr   = ovr_q;
    assign bus.ferr  = ferr_q;
`ifdef SERIAL_RX_PARITY_EN
    assign bus.perr  = perr_q;
`else
    assign bus.perr  = 1'b0;
`endif
endmodule

// File: tb/tb_serial_word_receiver.sv
// Scoreboard bench for serial_word_receiver (WIDTH=4): stimulus pushes expected words,
// a negedge monitor pops and compares whenever a new word appears on Q/valid.
module tb_serial_word_receiver;
    typedef struct {
        logic [3:0] q;
        logic       perr;
    } exp_t;

    logic clk;
    logic clr;
    int   checks;
    int   failures;
    exp_t sb[$];

    serial_word_receiver_if #(.WIDTH(4)) bus ();

    serial_word_receiver #(.WIDTH(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Sends the 4 data bits in the order seq[3], seq[2], seq[1], seq[0], then the parity bit when enabled.
    task automatic send_frame(input logic d, input logic [3:0] seq, input logic par, input logic ack_last);
        logic [4:0] bits;
        int         n;
        bits = {seq, par};
`ifdef SERIAL_RX_PARITY_EN
        n = 5;
`else
        n = 4;
`endif
        bus.dir   = d;
        bus.frame = 1'b1;
        for (int i = 0; i < n; i++) begin
            bus.sin = bits[4-i];
            bus.sen = 1'b1;
            bus.ack = ack_last && (i == n - 1);
            @(posedge clk); #1;
        end
        bus.sen   = 1'b0;
        bus.ack   = 1'b0;
        bus.frame = 1'b0;
        bus.sin   = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic expect_word(input logic [3:0] q, input logic perr);
        exp_t e;
        e.q    = q;
        e.perr = perr;
        sb.push_back(e);
    endtask

    task automatic do_ack();
        bus.ack = 1'b1;
        @(posedge clk); #1;
        bus.ack = 1'b0;
    endtask

    // Monitor: a new word is presented when valid rises or Q changes while valid is held.
    initial begin
        logic       prev_valid;
        logic [3:0] prev_q;
        exp_t       e;
        prev_valid = 1'b0;
        prev_q     = '0;
        forever begin
            @(negedge clk);
            if (bus.valid && (!prev_valid || bus.Q != prev_q)) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got Q=%0h with no expected word queued", bus.Q);
                end else begin
                    e = sb.pop_front();
                    check("sb_q", 32'(bus.Q), 32'(e.q));
                    check("sb_perr", 32'(bus.perr), 32'(e.perr));
                end
            end
            prev_valid = bus.valid;
            prev_q     = bus.Q;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        failures  = 0;
        clr       = 1'b1;
        bus.frame = 1'b0;
        bus.sen   = 1'b0;
        bus.sin   = 1'b0;
        bus.dir   = 1'b0;
        bus.ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q", 32'(bus.Q), 0);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_ovr", 32'(bus.ovr), 0);
        check("rst_ferr", 32'(bus.ferr), 0);
        check("rst_perr", 32'(bus.perr), 0);
        clr = 1'b0;
        @(posedge clk); #1;

        // Strobes without frame are ignored.
        bus.sen = 1'b1;
        bus.sin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.sen = 1'b0;
        bus.sin = 1'b0;
        check("sen_no_frame_valid", 32'(bus.valid), 0);

        // LSB first: 1,0,1,1 -> 1101; ack clears valid on the next edge.
        expect_word(4'b1101, 1'b0);
        send_frame(1'b0, 4'b1011, 1'b1, 1'b0);
        check("lsb_valid", 32'(bus.valid), 1);
        do_ack();
        check("ack_clears_valid", 32'(bus.valid), 0);

        // MSB first: 1,0,1,1 -> 1011; then LSB first 0,1,1,0 -> 0110.
        expect_word(4'b1011, 1'b0);
        send_frame(1'b1, 4'b1011, 1'b1, 1'b0);
        do_ack();
        expect_word(4'b0110, 1'b0);
        send_frame(1'b0, 4'b0110, 1'b0, 1'b0);
        do_ack();

        // Overrun: second word (0,1,0,0 -> 0010) dropped without ack.
        expect_word(4'b1101, 1'b0);
        send_frame(1'b0, 4'b1011, 1'b1, 1'b0);
        send_frame(1'b0, 4'b0100, 1'b1, 1'b0);
        check("ovr_q_held", 32'(bus.Q), 32'(4'b1101));
        check("ovr_set", 32'(bus.ovr), 1);
        do_ack();
        check("ovr_ack_valid", 32'(bus.valid), 0);
        check("ovr_sticky", 32'(bus.ovr), 1);
        clr = 1'b1;
        #1;
        check("ovr_cleared_by_clr", 32'(bus.ovr), 0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;

        // Ack on the completing edge of the second frame: new word replaces old, no overrun.
        expect_word(4'b1101, 1'b0);
        send_frame(1'b0, 4'b1011, 1'b1, 1'b0);
        expect_word(4'b0010, 1'b0);
        send_frame(1'b0, 4'b0100, 1'b1, 1'b1);
        check("simul_q", 32'(bus.Q), 32'(4'b0010));
        check("simul_valid", 32'(bus.valid), 1);
        check("simul_ovr", 32'(bus.ovr), 0);
        do_ack();

        // Short frame: two bits then frame drops -> one-cycle ferr pulse.
        bus.dir   = 1'b0;
        bus.frame = 1'b1;
        bus.sen   = 1'b1;
        bus.sin   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.frame = 1'b0;
        bus.sen   = 1'b0;
        bus.sin   = 1'b0;
        check("ferr_not_early", 32'(bus.ferr), 0);
        @(posedge clk);
        @(negedge clk);
        check("ferr_pulse", 32'(bus.ferr), 1);
        @(negedge clk);
        check("ferr_one_cycle", 32'(bus.ferr), 0);
        check("ferr_valid", 32'(bus.valid), 0);
        @(posedge clk); #1;
        expect_word(4'b0111, 1'b0);
        send_frame(1'b0, 4'b1110, 1'b1, 1'b0);
        do_ack();

        // clr mid-frame with a word held: outputs clear at once, next frame is received.
        expect_word(4'b1101, 1'b0);
        send_frame(1'b0, 4'b1011, 1'b1, 1'b0);
        bus.frame = 1'b1;
        bus.sen   = 1'b1;
        bus.sin   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        clr = 1'b1;
        #1;
        check("clr_q", 32'(bus.Q), 0);
        check("clr_valid", 32'(bus.valid), 0);
        check("clr_ovr", 32'(bus.ovr), 0);
        check("clr_ferr", 32'(bus.ferr), 0);
        check("clr_perr", 32'(bus.perr), 0);
        bus.frame = 1'b0;
        bus.sen   = 1'b0;
        bus.sin   = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk); #1;
        expect_word(4'b1111, 1'b0);
        send_frame(1'b0, 4'b1111, 1'b0, 1'b0);
        do_ack();

        // Parity: data 1,0,1,1 with parity 1 then parity 0.
        expect_word(4'b1101, 1'b0);
        send_frame(1'b0, 4'b1011, 1'b1, 1'b0);
        do_ack();
`ifdef SERIAL_RX_PARITY_EN
        expect_word(4'b1101, 1'b1);
`else
        expect_word(4'b1101, 1'b0);
`endif
        send_frame(1'b0, 4'b1011, 1'b0, 1'b0);
        do_ack();

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
